// File: rtl/motion_pkg.sv
// Shared types and helpers for the motion-highlighting pipeline blocks.
package motion_pkg;

  typedef enum logic [1:0] {
    MODE_PASS      = 2'd0,
    MODE_OVERLAY   = 2'd1,
    MODE_BLEND     = 2'd2,
    MODE_MASK_ONLY = 2'd3
  } mode_t;

  // Widest channel the blend helper handles; callers zero-extend and truncate back.
  localparam int unsigned BLEND_W = 16;

  // Per-channel floor average. The extra sum bit keeps the carry so the result never wraps.
  function automatic logic [BLEND_W-1:0] blend_px(input logic [BLEND_W-1:0] a,
                                                  input logic [BLEND_W-1:0] b);
    logic [BLEND_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[BLEND_W:1];
  endfunction

endpackage

// File: rtl/motion_overlay_if.sv
// FIFO-side handshake bundle for motion_overlay: mask and base show-ahead read ports plus the
// output FIFO write port. The overlay core is the master; the FIFOs sit on the slave side.
interface motion_overlay_if #(
  parameter int unsigned MASK_WIDTH = 8,
  parameter int unsigned PIX_WIDTH  = 24
);

  logic [MASK_WIDTH-1:0] mask_dout;
  logic                  mask_empty;
  logic                  mask_rd_en;
  logic [PIX_WIDTH-1:0]  base_dout;
  logic                  base_empty;
  logic                  base_rd_en;
  logic [PIX_WIDTH-1:0]  z_din;
  logic                  z_full;
  logic                  z_wr_en;

  modport master (
    input  mask_dout, mask_empty, base_dout, base_empty, z_full,
    output mask_rd_en, base_rd_en, z_din, z_wr_en
  );

  modport slave (
    output mask_dout, mask_empty, base_dout, base_empty, z_full,
    input  mask_rd_en, base_rd_en, z_din, z_wr_en
  );

endinterface

// File: rtl/motion_pixel_mux.sv
// Purely combinational compositor: one base pixel plus one mask word -> displayed pixel.
module motion_pixel_mux
  import motion_pkg::*;
#(
  parameter int unsigned CH_WIDTH   = 8,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned MASK_WIDTH = 8,
  parameter logic [CH_WIDTH*CHANNELS-1:0] HIGHLIGHT = 24'hFF00FF,
  localparam int unsigned PIX_WIDTH = CH_WIDTH * CHANNELS
) (
  input  logic [PIX_WIDTH-1:0]  base,
  input  logic [MASK_WIDTH-1:0] mask,
  input  mode_t                 mode,
  output logic [PIX_WIDTH-1:0]  pixel,
  output logic                  motion
);

  // Per-channel composite; any non-zero mask word marks the pixel as motion.
  always_comb begin
    motion = |mask;
    pixel  = base;
    for (int c = 0; c < CHANNELS; c++) begin
      unique case (mode)
        MODE_PASS: begin
          pixel[c*CH_WIDTH +: CH_WIDTH] = base[c*CH_WIDTH +: CH_WIDTH];
        end
        MODE_OVERLAY: begin
          pixel[c*CH_WIDTH +: CH_WIDTH] = motion ? HIGHLIGHT[c*CH_WIDTH +: CH_WIDTH]
                                                 : base[c*CH_WIDTH +: CH_WIDTH];
        end
        MODE_BLEND: begin
          pixel[c*CH_WIDTH +: CH_WIDTH] = motion
              ? CH_WIDTH'(blend_px(BLEND_W'(base[c*CH_WIDTH +: CH_WIDTH]),
                                   BLEND_W'(HIGHLIGHT[c*CH_WIDTH +: CH_WIDTH])))
              : base[c*CH_WIDTH +: CH_WIDTH];
        end
        MODE_MASK_ONLY: begin
          pixel[c*CH_WIDTH +: CH_WIDTH] = motion ? HIGHLIGHT[c*CH_WIDTH +: CH_WIDTH]
                                                 : '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/motion_overlay.sv
// Streaming motion overlay: pops paired mask/base words, composites them through a one-deep
// output register at 1 pixel/clock, and reports the motion-pixel count of each finished frame.
module motion_overlay
  import motion_pkg::*;
#(
  parameter int unsigned CH_WIDTH     = 8,
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned MASK_WIDTH   = 8,
  parameter logic [CH_WIDTH*CHANNELS-1:0] HIGHLIGHT = 24'hFF00FF,
  parameter int unsigned FRAME_PIXELS = 307200,
  localparam int unsigned PIX_WIDTH   = CH_WIDTH * CHANNELS,
  localparam int unsigned CNT_W       = $clog2(FRAME_PIXELS + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       mode,
  motion_overlay_if.master fifo,
  output logic [CNT_W-1:0] motion_count,
  output logic             count_valid
);

  logic                 out_valid_q, out_valid_d;
  logic [PIX_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     running_q, running_d;
  logic [CNT_W-1:0]     motion_count_q, motion_count_d;
  logic                 count_valid_q, count_valid_d;
  mode_t                mode_q, mode_d;

  logic                 pop;
  logic                 push;
  logic                 frame_start;
  logic                 frame_end;
  mode_t                eff_mode;
  logic [PIX_WIDTH-1:0] comp_px;
  logic                 comp_motion;

  // Handshake; pops are gated by reset so nothing is consumed while reset is asserted.
  always_comb begin
    push = out_valid_q & ~fifo.z_full;
    pop  = reset_n & ~fifo.mask_empty & ~fifo.base_empty & (~out_valid_q | ~fifo.z_full);
  end

  assign fifo.mask_rd_en = pop;
  assign fifo.base_rd_en = pop;
  assign fifo.z_din      = out_data_q;
  assign fifo.z_wr_en    = push;
  assign motion_count    = motion_count_q;
  assign count_valid     = count_valid_q;

  // The first pixel of a frame uses the live mode input; the rest of the frame uses the latch.
  always_comb begin
    frame_start = (idx_q == '0);
    frame_end   = (idx_q == CNT_W'(FRAME_PIXELS - 1));
    eff_mode    = frame_start ? mode_t'(mode) : mode_q;
  end

  motion_pixel_mux #(
    .CH_WIDTH   (CH_WIDTH),
    .CHANNELS   (CHANNELS),
    .MASK_WIDTH (MASK_WIDTH),
    .HIGHLIGHT  (HIGHLIGHT)
  ) u_mux (
    .base   (fifo.base_dout),
    .mask   (fifo.mask_dout),
    .mode   (eff_mode),
    .pixel  (comp_px),
    .motion (comp_motion)
  );

  // Next state: output register, frame index, running count and per-frame result.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    idx_d          = idx_q;
    running_d      = running_q;
    motion_count_d = motion_count_q;
    count_valid_d  = 1'b0;
    mode_d         = mode_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = comp_px;
      if (frame_start) begin
        mode_d = eff_mode;
      end
      if (frame_end) begin
        idx_d          = '0;
        running_d      = '0;
        motion_count_d = running_q + CNT_W'(comp_motion);
        count_valid_d  = 1'b1;
      end else begin
        idx_d     = idx_q + CNT_W'(1);
        running_d = running_q + CNT_W'(comp_motion);
      end
    end else if (push) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      idx_q          <= '0;
      running_q      <= '0;
      motion_count_q <= '0;
      count_valid_q  <= 1'b0;
      mode_q         <= MODE_PASS;
    end else begin
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      idx_q          <= idx_d;
      running_q      <= running_d;
      motion_count_q <= motion_count_d;
      count_valid_q  <= count_valid_d;
      mode_q         <= mode_d;
    end
  end

endmodule
